counter_checker: RTL and testbench

COUNTER_CHECKER -- requirements
Module: counter_checker

---
 rtl/counter_checker.sv | 131 +++++++++++++
 tb/tb_counter_checker.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// Monitors an up-counter stream, locks after LOCK_COUNT consecutive +1 steps,
// then flags breaks and wraps. Define COUNTER_CHECKER_WRAP_CNT_EN to add the wrap_cnt output.
module counter_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [7:0]       err_cnt,
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
  output logic [7:0]       wrap_cnt,
`endif
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [3:0]       good_run_q, good_run_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] pred;
  logic [4:0]       run_inc;
  logic             match;
  logic             lock_hit;

  // Prediction wraps naturally because pred is exactly WIDTH bits wide.
  assign pred     = prev_q + 1'b1;
  assign match    = (cnt_in == pred);
  assign run_inc  = {1'b0, good_run_q} + 5'd1;
  assign lock_hit = (run_inc == LOCK_COUNT[4:0]);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    expected_d   = expected_q;
    good_run_d   = good_run_q;
    err_cnt_d    = err_cnt_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;

    if (!en) begin
      state_d = IDLE;
    end else begin
      prev_d     = cnt_in;
      expected_d = cnt_in + 1'b1;
      case (state_q)
        IDLE: begin
          good_run_d = 4'd0;
          state_d    = ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            good_run_d = run_inc[3:0];
            if (lock_hit) state_d = LOCKED;
          end else begin
            good_run_d = 4'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            wrap_pulse_d = (cnt_in == '0);
          end else begin
            err_pulse_d = 1'b1;
            good_run_d  = 4'd0;
            state_d     = ACQUIRE;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      expected_q   <= WIDTH'(1);
      good_run_q   <= 4'd0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      expected_q   <= expected_d;
      good_run_q   <= good_run_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

`ifdef COUNTER_CHECKER_WRAP_CNT_EN
  logic [7:0] wrap_cnt_q, wrap_cnt_d;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_pulse_d && wrap_cnt_q != 8'hFF) wrap_cnt_d = wrap_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) wrap_cnt_q <= 8'd0;
    else       wrap_cnt_q <= wrap_cnt_d;
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_cnt    = err_cnt_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker (WIDTH=4, LOCK_COUNT=2): directed scenarios
// plus random streams, compared against a behavioural model of the checking rules.
module tb_counter_checker;

  localparam int W  = 4;
  localparam int LC = 2;

  logic         clk = 1'b0;
  logic         rstn;
  logic         en;
  logic [W-1:0] cnt_in;
  logic         locked;
  logic         err_pulse;
  logic         wrap_pulse;
  logic [7:0]   err_cnt;
  logic [W-1:0] expected;
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
  logic [7:0]   wrap_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: abstract view of the checking rules.
  bit m_active;   // a previous sample exists since the last idle/reset
  bit m_locked;
  int m_prev;
  int m_run;
  int m_errs;
  int m_wraps;
  bit m_err;
  bit m_wrap;

  counter_checker #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .cnt_in     (cnt_in),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_cnt    (err_cnt),
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    .wrap_cnt   (wrap_cnt),
`endif
    .expected   (expected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input int c);
    m_err  = 0;
    m_wrap = 0;
    if (!r) begin
      m_active = 0; m_locked = 0; m_prev = 0; m_run = 0; m_errs = 0; m_wraps = 0;
    end else if (!e) begin
      m_active = 0; m_locked = 0;
    end else if (!m_active) begin
      m_active = 1; m_prev = c; m_run = 0;
    end else begin
      bit ok;
      ok = (c == (m_prev + 1) % (1 << W));
      if (m_locked) begin
        if (ok) begin
          m_wrap = (c == 0);
          if (m_wrap && m_wraps < 255) m_wraps++;
        end else begin
          m_err = 1; m_locked = 0; m_run = 0;
          if (m_errs < 255) m_errs++;
        end
      end else if (ok) begin
        m_run++;
        if (m_run == LC) m_locked = 1;
      end else begin
        m_run = 0;
      end
      m_prev = c;
    end
  endtask

  task automatic step(input bit r, input bit e, input int c);
    rstn   = r;
    en     = e;
    cnt_in = W'(c);
    @(posedge clk);
    model(r, e, c);
    #1;
    check("locked",     int'(locked),     int'(m_locked));
    check("err_pulse",  int'(err_pulse),  int'(m_err));
    check("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
    check("err_cnt",    int'(err_cnt),    m_errs);
    check("expected",   int'(expected),   (m_prev + 1) % (1 << W));
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    check("wrap_cnt",   int'(wrap_cnt),   m_wraps);
`endif
    $display("step rstn=%0b en=%0b cnt_in=%0d -> locked=%0b err=%0b wrap=%0b err_cnt=%0d expected=%0d",
             r, e, c, locked, err_pulse, wrap_pulse, err_cnt, expected);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; cnt_in = '0;
    m_active = 0; m_locked = 0; m_prev = 0; m_run = 0; m_errs = 0; m_wraps = 0;
    m_err = 0; m_wrap = 0;

    // Reset state
    step(0, 0, 0);
    step(0, 1, 7);

    // Lock on 0,1,2 then run through a wrap
    for (int v = 0; v <= 15; v++) step(1, 1, v);
    step(1, 1, 0);
    step(1, 1, 1);

    // Break at 5 -> 9, relock on 10,11
    for (int v = 2; v <= 5; v++) step(1, 1, v);
    step(1, 1, 9);
    step(1, 1, 10);
    step(1, 1, 11);

    // Repeated value while locked counts as a mismatch
    step(1, 1, 11);

    // Idle, then acquire with 3,7,8,9
    step(1, 0, 4);
    step(1, 1, 3);
    step(1, 1, 7);
    step(1, 1, 8);
    step(1, 1, 9);

    // Reset mid-lock while the stream keeps going
    step(1, 1, 10);
    step(0, 1, 11);
    step(1, 1, 12);
    step(1, 1, 13);
    step(1, 1, 14);

    // Random streams, mostly well-formed
    for (int i = 0; i < 400; i++) begin
      int c;
      bit e;
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 3) != 0) ? (m_prev + 1) % 16 : int'($urandom_range(0, 15));
      step(($urandom_range(0, 99) != 0), e, c);
    end

    // Saturate the error counter: mismatch then relock, 300 times
    step(1, 1, 0);
    step(1, 1, 1);
    step(1, 1, 2);
    for (int i = 0; i < 300; i++) begin
      step(1, 1, (m_prev + 3) % 16);
      step(1, 1, (m_prev + 1) % 16);
      step(1, 1, (m_prev + 1) % 16);
    end
    check("err_cnt_sat", int'(err_cnt), 255);
    for (int i = 0; i < 3; i++) step(1, 0, i);
    check("err_cnt_hold", int'(err_cnt), 255);
    check("unlocked_after_idle", int'(locked), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
